sio_host_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `sio_host` command port among `NREQ` requesters. It accepts one 80-bit command at a time and drives it to the host as a single-cycle `wvalid` pulse. It then holds off further commands for the link's transfer time. For read commands it captures the host's `rdata` after a fixed latency and returns it, tagged with the requester index.

---
 rtl/sio_pkg.sv | 21 ++
 rtl/sio_rr_pick.sv | 31 +++
 rtl/sio_host_arb.sv | 126 ++++++++++++
 tb/tb_sio_host_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sio_pkg.sv
// sio_pkg: shared types and widths for the sio_host arbiter slice.
package sio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sio_state_e;

    localparam int SIO_CMD_W  = 80;
    localparam int SIO_RD_BIT = 79;
    localparam int SIO_DATA_W = 32;

    // Down-counter width covering both the write gap and the read latency.
    function automatic int sio_cnt_w(input int gap, input int lat);
        int m;
        m = (gap > lat) ? gap : lat;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sio_rr_pick.sv
// sio_rr_pick: combinational round-robin picker starting after last.
// SIO_ARB_PRIORITY_EN: requester 0 wins whenever it requests.
module sio_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] p;

    // Walk backwards so the nearest requester after last is written last and wins.
    always_comb begin
        any = |req;
        idx = '0;
        p   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            p = IDX_W'((int'(last) + k) % NREQ);
            if (req[p]) idx = p;
        end
`ifdef SIO_ARB_PRIORITY_EN
        if (req[0]) idx = '0;
`endif
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/sio_host_arb.sv
// sio_host_arb: shares one sio_host command port among NREQ requesters, returns read data.
// SIO_ARB_PRIORITY_EN: requester 0 takes strict priority over the round-robin.
module sio_host_arb
    import sio_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP        = 8,
    parameter int RD_LATENCY = 12
) (
    input  logic                        c,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*SIO_CMD_W-1:0]   req_wdata,
    output logic [NREQ-1:0]             req_ready,
    output logic                        rvalid,
    output logic [$clog2(NREQ)-1:0]     rid,
    output logic [SIO_DATA_W-1:0]       rdata,
    output logic                        host_wvalid,
    output logic [SIO_CMD_W-1:0]        host_wdata,
    input  logic [SIO_DATA_W-1:0]       host_rdata
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = sio_cnt_w(GAP, RD_LATENCY);

    sio_state_e              state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    host_wvalid_q, host_wvalid_d;
    logic [SIO_CMD_W-1:0]    host_wdata_q, host_wdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [IDX_W-1:0]        rid_q, rid_d;
    logic [SIO_DATA_W-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0]         pick_gnt;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic                    accept;
    logic [SIO_CMD_W-1:0]    req_cmd [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cmd
        assign req_cmd[i] = req_wdata[i*SIO_CMD_W +: SIO_CMD_W];
    end

    sio_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req_valid),
        .last (last_q),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Ready is suppressed while reset is asserted so no requester drops its command.
    assign accept    = rst_n && (state_q == IDLE) && pick_any;
    assign req_ready = accept ? pick_gnt : '0;

    assign host_wvalid = host_wvalid_q;
    assign host_wdata  = host_wdata_q;
    assign rvalid      = rvalid_q;
    assign rid         = rid_q;
    assign rdata       = rdata_q;

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        host_wvalid_d = 1'b0;
        host_wdata_d  = host_wdata_q;
        rvalid_d      = 1'b0;
        rid_d         = rid_q;
        rdata_d       = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = ISSUE;
                    last_d        = pick_idx;
                    host_wvalid_d = 1'b1;
                    host_wdata_d  = req_cmd[pick_idx];
                end
            end
            ISSUE: begin
                cnt_d   = host_wdata_q[SIO_RD_BIT] ? CNT_W'(RD_LATENCY - 1) : CNT_W'(GAP - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (host_wdata_q[SIO_RD_BIT]) begin
                        rvalid_d = 1'b1;
                        rid_d    = last_q;
                        rdata_d  = host_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= IDX_W'(NREQ - 1);
            cnt_q         <= '0;
            host_wvalid_q <= 1'b0;
            host_wdata_q  <= '0;
            rvalid_q      <= 1'b0;
            rid_q         <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            host_wvalid_q <= host_wvalid_d;
            host_wdata_q  <= host_wdata_d;
            rvalid_q      <= rvalid_d;
            rid_q         <= rid_d;
            rdata_q       <= rdata_d;
        end
    end

endmodule

// File: tb/tb_sio_host_arb.sv
// tb_sio_host_arb: directed checks of arbitration, write/read timing and reset for sio_host_arb.
module tb_sio_host_arb;

    localparam int NREQ       = 4;
    localparam int GAP        = 8;
    localparam int RD_LATENCY = 12;

    logic               c = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*80-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready;
    logic               rvalid;
    logic [1:0]         rid;
    logic [31:0]        rdata;
    logic               host_wvalid;
    logic [79:0]        host_wdata;
    logic [31:0]        host_rdata;

    int total = 0;
    int bad   = 0;
    int hcnt  = 0;

    sio_host_arb #(
        .NREQ       (NREQ),
        .GAP        (GAP),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .c           (c),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rvalid      (rvalid),
        .rid         (rid),
        .rdata       (rdata),
        .host_wvalid (host_wvalid),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata)
    );

    always #5 c = ~c;

    // Host model: read data is valid only in the cycle RD_LATENCY after the wvalid cycle.
    always @(posedge c) hcnt <= host_wvalid ? 1 : (hcnt > 0 && hcnt < 1000) ? hcnt + 1 : hcnt;
    assign host_rdata = (hcnt == RD_LATENCY) ? 32'hCAFEF00D : 32'h0BAD0BAD;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge c);
    endtask

    task automatic do_reset();
        step();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    logic [79:0] d1, d2, rcmd;
    logic [3:0]  prio_exp [4];

    initial begin
        d1   = 80'h0000_1234_5678_9ABC_DEF0;
        d2   = 80'h0000_0000_0000_0000_5A5A;
        rcmd = {1'b1, 79'h00AB};
`ifdef SIO_ARB_PRIORITY_EN
        prio_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        prio_exp = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
`endif
        // reset held 3 cycles with every requester asking
        rst_n     = 1'b0;
        req_valid = '1;
        repeat (3) begin
            step();
            chk("rst_ready", 80'(req_ready), 80'(0));
            chk("rst_wvalid", 80'(host_wvalid), 80'(0));
            chk("rst_rvalid", 80'(rvalid), 80'(0));
            chk("rst_wdata", host_wdata, 80'(0));
        end
        step();
        rst_n     = 1'b1;
        req_valid = '0;
        #1;
        chk("rst_rid", 80'(rid), 80'(0));
        chk("rst_rdata", 80'(rdata), 80'(0));
        chk("idle_ready", 80'(req_ready), 80'(0));

        // single write from requester 1, then a back-to-back second one
        step();
        req_wdata[80 +: 80] = d1;
        req_valid = 4'b0010;
        #1 chk("wr_ready_T", 80'(req_ready), 80'(4'b0010));
        step();
        req_wdata[80 +: 80] = d2;
        #1;
        chk("wr_wvalid_T1", 80'(host_wvalid), 80'(1));
        chk("wr_wdata_T1", host_wdata, d1);
        chk("wr_ready_T1", 80'(req_ready), 80'(0));
        for (int k = 2; k <= 9; k++) begin
            step();
            #1;
            chk("wr_ready_busy", 80'(req_ready), 80'(0));
            chk("wr_wvalid_busy", 80'(host_wvalid), 80'(0));
        end
        step();
        #1 chk("wr_ready_T10", 80'(req_ready), 80'(4'b0010));
        step();
        req_valid = '0;
        #1;
        chk("wr2_wvalid", 80'(host_wvalid), 80'(1));
        chk("wr2_wdata", host_wdata, d2);

        // fairness: all four requesting continuously
        do_reset();
        for (int i = 0; i < NREQ; i++) req_wdata[i*80 +: 80] = 80'(32'h1000 + i);
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            #1 chk("rr_grant", 80'(req_ready), 80'(4'b0001 << (n % 4)));
            step();
            #1;
            chk("rr_wvalid", 80'(host_wvalid), 80'(1));
            chk("rr_wdata", host_wdata, 80'(32'h1000 + (n % 4)));
            repeat (GAP + 1) step();
        end

        // read from requester 2
        do_reset();
        req_wdata[160 +: 80] = rcmd;
        req_valid = 4'b0100;
        #1 chk("rd_ready_T", 80'(req_ready), 80'(4'b0100));
        step();
        req_valid = '0;
        #1 chk("rd_wvalid_T1", 80'(host_wvalid), 80'(1));
        for (int k = 2; k <= RD_LATENCY + 1; k++) begin
            step();
            #1 chk("rd_rvalid_early", 80'(rvalid), 80'(0));
        end
        step();
        #1;
        chk("rd_rvalid", 80'(rvalid), 80'(1));
        chk("rd_rid", 80'(rid), 80'(2));
        chk("rd_rdata", 80'(rdata), 80'(32'hCAFEF00D));
        step();
        #1;
        chk("rd_rvalid_pulse", 80'(rvalid), 80'(0));
        chk("rd_rdata_hold", 80'(rdata), 80'(32'hCAFEF00D));

        // reset while waiting for read data
        do_reset();
        req_valid = 4'b0100;
        #1 chk("rw_ready_T", 80'(req_ready), 80'(4'b0100));
        step();
        req_valid = '0;
        repeat (3) step();
        rst_n     = 1'b0;
        req_valid = 4'b0110;
        #1 chk("rw_ready_in_rst", 80'(req_ready), 80'(0));
        step();
        rst_n = 1'b1;
        #1 chk("rw_first_grant", 80'(req_ready), 80'(4'b0010));
        step();
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            #1 chk("rw_no_rvalid", 80'(rvalid), 80'(0));
            step();
        end

        // requesters 0 and 3 continuously
        do_reset();
        req_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            #1 chk("prio_grant", 80'(req_ready), 80'(prio_exp[n]));
            repeat (GAP + 2) step();
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
